// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode encoding and init patterns
// shared by the LED pattern generator and its bench.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam int PWM_W = 8;

  function automatic logic [31:0] init_pat(
    input mode_e m,
    input int    w
  );
    logic [31:0] r;
    unique case (m)
      MODE_CHASE,
      MODE_BOUNCE: r = 32'd1;
      default:     r = '0;
    endcase
    if (w < 1)
      r = '0;
    else if (w < 32)
      r = r & ((32'd1 << w) - 32'd1);
    return r;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: divide-by-DIV step counter, one-cycle
// TICK on the last count; held at zero while EN is low.
module led_prescaler #(
  parameter int DIV = 25000000
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic EN,
  output logic TICK
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      cnt <= '0;
    else if (!EN)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: NUM_LEDS pattern driver (blink/chase/
// count/bounce). Optional dimming via LED_PWM_DIM_EN.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS     = 4,
  parameter int PRESCALE_DIV = 25000000,
  parameter int RESET_MODE   = 0,
  parameter int DIM_DUTY     = 64
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                LOCK,
  input  logic [1:0]          MODE,
  input  logic                MODE_VLD,
  output logic [NUM_LEDS-1:0] LED,
  output logic                TICK,
  output logic [1:0]          CUR_MODE
);

  localparam mode_e RST_MODE = mode_e'(2'(RESET_MODE));

  if (NUM_LEDS < 1 || NUM_LEDS > 32 ||
      PRESCALE_DIV < 2 || DIM_DUTY < 0) begin : g_bad_param
    $error("led_pattern_gen: illegal parameter");
  end

  logic sync1;
  logic lock_s;
  logic tick;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= LOCK;
      lock_s <= sync1;
    end
  end

  led_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_presc (
    .CLK    (CLK),
    .RESETn (RESETn),
    .EN     (lock_s),
    .TICK   (tick)
  );

  mode_e cur;
  mode_e pend;
  mode_e eff;

  logic [NUM_LEDS-1:0] pat;
  logic [NUM_LEDS-1:0] pat_nxt;
  logic [NUM_LEDS-1:0] stepped;
  logic [NUM_LEDS-1:0] init_v;
  logic [NUM_LEDS-1:0] led_q;
  logic                dir;
  logic                dir_nxt;
  logic                step_dir;

  // a strobe in the tick cycle wins over the held request
  assign eff    = MODE_VLD ? mode_e'(MODE) : pend;
  assign init_v = NUM_LEDS'(init_pat(eff, NUM_LEDS));

  always_comb begin
    stepped  = pat;
    step_dir = dir;
    unique case (cur)
      MODE_BLINK: stepped = ~pat;
      MODE_CHASE:
        stepped = (pat << 1) | (pat >> (NUM_LEDS - 1));
      MODE_COUNT: stepped = pat + NUM_LEDS'(1);
      MODE_BOUNCE: begin
        if (NUM_LEDS == 1) begin
          stepped = pat;
        end else if (dir) begin
          if (pat[NUM_LEDS-1]) begin
            stepped  = pat >> 1;
            step_dir = 1'b0;
          end else begin
            stepped = pat << 1;
          end
        end else begin
          if (pat[0]) begin
            stepped  = pat << 1;
            step_dir = 1'b1;
          end else begin
            stepped = pat >> 1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pat_nxt = pat;
    dir_nxt = dir;
    if (!lock_s || (tick && eff != cur)) begin
      pat_nxt = init_v;
      dir_nxt = 1'b1;
    end else if (tick) begin
      pat_nxt = stepped;
      dir_nxt = step_dir;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cur   <= RST_MODE;
      pend  <= RST_MODE;
      pat   <= '0;
      dir   <= 1'b1;
      led_q <= '0;
    end else begin
      if (MODE_VLD)
        pend <= mode_e'(MODE);
      if (!lock_s || tick)
        cur <= eff;
      pat <= pat_nxt;
      dir <= dir_nxt;
      // sync1 is next cycle's lock_s: blank with it
      led_q <= sync1 ? pat_nxt : '0;
    end
  end

  assign TICK     = tick;
  assign CUR_MODE = cur;

`ifdef LED_PWM_DIM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic             dim_on;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      pwm_cnt <= '0;
    else if (lock_s)
      pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign dim_on = (DIM_DUTY >= (1 << PWM_W)) ||
                  (int'(pwm_cnt) < DIM_DUTY);
  assign LED = led_q & {NUM_LEDS{dim_on}};
`else
  assign LED = led_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench, expected LED and
// mode queued per tick, popped by an independent monitor.
module tb_led_pattern_gen;

  logic       CLK;
  logic       RESETn;
  logic       LOCK;
  logic [1:0] MODE;
  logic       MODE_VLD;
  logic [3:0] LED;
  logic       TICK;
  logic [1:0] CUR_MODE;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] led;
    logic [1:0] mode;
  } exp_t;

  exp_t sb[$];

  led_pattern_gen #(
    .NUM_LEDS     (4),
    .PRESCALE_DIV (4),
    .RESET_MODE   (0),
    .DIM_DUTY     (64)
  ) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .LOCK     (LOCK),
    .MODE     (MODE),
    .MODE_VLD (MODE_VLD),
    .LED      (LED),
    .TICK     (TICK),
    .CUR_MODE (CUR_MODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] l, input logic [1:0] m);
    sb.push_back('{led: l, mode: m});
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (TICK !== 1'b1 && k < 20);
    if (TICK !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL tick_timeout got=none want=tick");
    end
  endtask

  task automatic strobe(input logic [1:0] m);
    MODE     = m;
    MODE_VLD = 1'b1;
    @(negedge CLK);
    MODE_VLD = 1'b0;
  endtask

  // edge number (after LOCK rises) whose active edge consumes TICK
  task automatic first_tick(output int e);
    e = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (TICK === 1'b1) begin
        e = k + 1;
        break;
      end
    end
  endtask

  // monitor: every tick edge pops one expectation
  always @(negedge CLK) begin
    if (TICK === 1'b1) begin
      @(posedge CLK);
      #1;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty got=%b want=none", LED);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (LED !== e.led || CUR_MODE !== e.mode) begin
          bad++;
          $display("FAIL tick_led got=%b/%0d want=%b/%0d",
                   LED, CUR_MODE, e.led, e.mode);
        end
      end
    end
  end

  initial begin
    int e;
    int p;
    int ticks;
    RESETn   = 1'b0;
    LOCK     = 1'b0;
    MODE     = 2'd0;
    MODE_VLD = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_tick", 32'(TICK), 32'h0);
    chk("rst_mode", 32'(CUR_MODE), 32'h0);
    RESETn = 1'b1;
    @(negedge CLK);

    // blink after lock: 2 sync + 4 prescale
    push(4'b1111, 2'd0);
    push(4'b0000, 2'd0);
    LOCK = 1'b1;
    first_tick(e);
    chk("first_tick_edge", 32'(e), 32'd6);
    p = 0;
    do begin
      @(negedge CLK);
      p++;
    end while (TICK !== 1'b1 && p < 20);
    chk("tick_period", 32'(p), 32'd4);

    // chase, strobed mid-period
    @(negedge CLK);
    push(4'b0001, 2'd1);
    push(4'b0010, 2'd1);
    push(4'b0100, 2'd1);
    push(4'b1000, 2'd1);
    push(4'b0001, 2'd1);
    strobe(2'd1);
    repeat (5) wait_tick();

    // bounce
    @(negedge CLK);
    push(4'b0001, 2'd3);
    push(4'b0010, 2'd3);
    push(4'b0100, 2'd3);
    push(4'b1000, 2'd3);
    push(4'b0100, 2'd3);
    push(4'b0010, 2'd3);
    push(4'b0001, 2'd3);
    push(4'b0010, 2'd3);
    strobe(2'd3);
    repeat (8) wait_tick();

    // count, strobe coincident with a tick cycle
    for (int i = 0; i < 22; i++)
      push(4'(i % 16), 2'd2);
    @(negedge CLK);
    wait_tick();
    strobe(2'd2);
    repeat (21) wait_tick();

    // drop lock at LED=0101
    @(negedge CLK);
    chk("pre_drop_led", 32'(LED), 32'h5);
    LOCK = 1'b0;
    @(negedge CLK);
    chk("drop_led_1", 32'(LED), 32'h5);
    @(negedge CLK);
    chk("drop_led_2", 32'(LED), 32'h0);
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (TICK !== 1'b0) ticks++;
    end
    chk("unlocked_ticks", 32'(ticks), 32'd0);
    chk("unlocked_led", 32'(LED), 32'h0);

    // unlocked strobes apply at once
    strobe(2'd3);
    chk("unlocked_mode3", 32'(CUR_MODE), 32'd3);
    strobe(2'd2);
    chk("unlocked_mode2", 32'(CUR_MODE), 32'd2);

    // restore: first tick steps the reloaded count
    push(4'b0001, 2'd2);
    LOCK = 1'b1;
    first_tick(e);
    chk("relock_tick_edge", 32'(e), 32'd6);

    // two strobes in one period, last wins
    @(negedge CLK);
    push(4'b0001, 2'd1);
    push(4'b0010, 2'd1);
    strobe(2'd2);
    strobe(2'd1);
    repeat (2) wait_tick();

    // blink all-on phase
    @(negedge CLK);
    push(4'b0000, 2'd0);
    push(4'b1111, 2'd0);
    strobe(2'd0);
    repeat (2) wait_tick();
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
`ifdef LED_PWM_DIM_EN
      total++;
      if (LED !== 4'b0000 && LED !== 4'b1111) begin
        bad++;
        $display("FAIL dim_led got=%b want=0000|1111", LED);
      end
`else
      chk("blink_on", 32'(LED), 32'hf);
`endif
      @(negedge CLK);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);

    // async reset mid-pattern
    #2;
    RESETn = 1'b0;
    #1;
    chk("arst_led", 32'(LED), 32'h0);
    chk("arst_tick", 32'(TICK), 32'h0);
    chk("arst_mode", 32'(CUR_MODE), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
